matmul_sequencer: RTL and testbench
===================================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 Parameter DATA_W, default 8: element and register width in bits.
REQ-002 Parameter ADDR_W, default 3: register-file address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request pulse; decoded matrix-multiply R-type instruction valid in execute.
REQ-006 dest_base  input  ADDR_W  first destination register of the result.
REQ-007 a_mat  input  4*DATA_W  matrix A, packed {a11,a10,a01,a00}, a00 in LSBs.
REQ-008 b_mat  input  4*DATA_W  matrix B, packed {b11,b10,b01,b00}.
REQ-009 flush  input  1  pipeline flush; abort the operation in progress.
REQ-010 stall  output  1  freezes fetch/decode/execute while high.
REQ-011 busy  output  1  sequencer not in IDLE.
REQ-012 wr_en  output  1  register-file write strobe.
REQ-013 wr_addr  output  ADDR_W  register-file write address.
REQ-014 wr_data  output  DATA_W  register-file write data.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE, with a 2-bit element index k.
REQ-017 In IDLE with start=1 and flush=0, the block SHALL latch a_mat, b_mat and dest_base, clear k and enter RUN.
REQ-018 In RUN, each cycle SHALL assert wr_en with wr_addr=(dest_base+k) mod 2^ADDR_W and wr_data=c(k), using the order k=0..3 -> c00,c01,c10,c11.
REQ-019 The element value SHALL be c_ij = a_i0*b_0j + a_i1*b_1j, computed on unsigned operands at full width of 2*DATA_W+1 bits, then reduced per REQ-030/031.
REQ-020 After the k=3 write, the block SHALL enter DONE; DONE SHALL assert done for one cycle and then return to IDLE.
REQ-021 Timing: start sampled at edge 0; writes occur in cycles 1-4; done occurs in cycle 5; the next start is accepted in cycle 6.
REQ-022 stall SHALL equal (IDLE & start & ~flush) | RUN; it SHALL be low in DONE, so the instruction retires alongside done.
REQ-023 busy SHALL be high in RUN and DONE.
REQ-024 A start asserted while busy SHALL be ignored, with no queuing.
REQ-025 flush SHALL have priority: wr_en is forced to 0 in the flush cycle, the FSM goes to IDLE at the next edge, done is not pulsed, and writes already made remain.
REQ-026 start and flush high together in IDLE SHALL leave the FSM in IDLE.
REQ-027 Outside RUN, wr_en=0, and wr_addr and wr_data SHALL hold 0.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, k=0, latched operands=0, stall=0, busy=0, wr_en=0, wr_addr=0, wr_data=0 and done=0, including in the middle of an operation.
REQ-029 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Configuration
REQ-030 Macro MATMUL_SAT_EN defined: wr_data SHALL be 2^DATA_W-1 when the full sum exceeds 2^DATA_W-1, and the sum otherwise.
REQ-031 Macro MATMUL_SAT_EN undefined: wr_data SHALL be the low DATA_W bits of the sum (wrap-around).

Verification
REQ-032 Identity: A={1,0,0,1} (a00,a01,a10,a11), B={5,6,7,8}, dest_base=2, start -> writes r2=5, r3=6, r4=7, r5=8 in cycles 1-4, done in cycle 5, stall high in cycles 0-4.
REQ-033 Overflow: all a and b elements=16 -> every sum is 512; each element is 0x00 without MATMUL_SAT_EN and 0xFF with it.
REQ-034 Address wrap: dest_base=6 -> wr_addr sequence 6, 7, 0, 1.
REQ-035 Flush: flush in the k=2 cycle -> only writes k=0 and k=1 occur, no done pulse, IDLE next cycle, stall low.
REQ-036 Busy start: start repulsed in cycles 2 and 5 -> ignored; exactly 4 writes and 1 done pulse.
REQ-037 Reset: rst_n pulled low in cycle 3 without a clock edge -> all outputs are 0 immediately; after release, a new start runs normally.

Source files
------------

// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if: issue/flush handshake and register-file write port of the 2x2 matmul sequencer
interface matmul_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic start;
  logic [ADDR_W-1:0] dest_base;
  logic [4*DATA_W-1:0] a_mat;
  logic [4*DATA_W-1:0] b_mat;
  logic flush;
  logic stall;
  logic busy;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic done;
  modport master (
    output start, dest_base, a_mat, b_mat, flush,
    input  stall, busy, wr_en, wr_addr, wr_data, done
  );
  modport slave (
    input  start, dest_base, a_mat, b_mat, flush,
    output stall, busy, wr_en, wr_addr, wr_data, done
  );
endinterface

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: 2x2 matrix multiply written back one element per cycle; MATMUL_SAT_EN selects saturating results
module matmul_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input logic clk,
  input logic rst_n,
  matmul_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [1:0] k;
  logic [4*DATA_W-1:0] a_q, b_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] a0, a1, b0, b1, elem;
  logic [2*DATA_W:0] sum;
  logic run;
  always_comb begin
    a0 = a_q[DATA_W*{k[1], 1'b0} +: DATA_W];
    a1 = a_q[DATA_W*{k[1], 1'b1} +: DATA_W];
    b0 = b_q[DATA_W*{1'b0, k[0]} +: DATA_W];
    b1 = b_q[DATA_W*{1'b1, k[0]} +: DATA_W];
    sum = {{(DATA_W+1){1'b0}}, a0} * {{(DATA_W+1){1'b0}}, b0}
        + {{(DATA_W+1){1'b0}}, a1} * {{(DATA_W+1){1'b0}}, b1};
`ifdef MATMUL_SAT_EN
    elem = |sum[2*DATA_W:DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
    elem = sum[DATA_W-1:0];
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      k      <= '0;
      a_q    <= '0;
      b_q    <= '0;
      base_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start && !bus.flush) begin
          state  <= RUN;
          k      <= '0;
          a_q    <= bus.a_mat;
          b_q    <= bus.b_mat;
          base_q <= bus.dest_base;
        end
        RUN: begin
          k     <= bus.flush ? 2'd0 : k + 2'd1;
          state <= bus.flush ? IDLE : (k == 2'd3 ? DONE : RUN);
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign run          = state == RUN;
  assign bus.stall    = rst_n & ((state == IDLE & bus.start & ~bus.flush) | run);
  assign bus.busy     = state != IDLE;
  assign bus.wr_en    = run & ~bus.flush;
  assign bus.wr_addr  = run ? base_q + ADDR_W'(k) : '0;
  assign bus.wr_data  = run ? elem : '0;
  assign bus.done     = state == DONE;
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed and random 2x2 matmul operations checked against a matrix-product model
module tb_matmul_sequencer;
  logic clk = 0;
  logic rst_n = 0;
  int n_cmp = 0;
  int n_err = 0;
  matmul_sequencer_if #(.DATA_W(8), .ADDR_W(3)) bus ();
  matmul_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model(input logic [31:0] a, input logic [31:0] b, input int i, input int j);
    int s;
    s = a[(2*i)*8 +: 8] * b[j*8 +: 8] + a[(2*i+1)*8 +: 8] * b[(2+j)*8 +: 8];
`ifdef MATMUL_SAT_EN
    return s > 255 ? 255 : s;
`else
    return s % 256;
`endif
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_wr_addr"}, bus.wr_addr, 0);
    chk({tag, "_wr_data"}, bus.wr_data, 0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] base,
                        input int flush_c, input bit restart);
    @(posedge clk); #1;
    bus.start = 1; bus.flush = 0; bus.a_mat = a; bus.b_mat = b; bus.dest_base = base;
    #3;
    chk("c0_stall", bus.stall, 1);
    chk_idle("c0");
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      bus.start = restart && (c == 2 || c == 5);
      bus.flush = (c == flush_c);
      bus.a_mat = $urandom; bus.b_mat = $urandom; bus.dest_base = 3'($urandom);
      #3;
      if (c <= 4) begin
        chk("run_wr_en", bus.wr_en, c != flush_c);
        chk("run_stall", bus.stall, 1);
        chk("run_busy", bus.busy, 1);
        chk("run_done", bus.done, 0);
        if (c != flush_c) begin
          chk("run_wr_addr", bus.wr_addr, (base + c - 1) % 8);
          chk("run_wr_data", bus.wr_data, model(a, b, (c - 1) / 2, (c - 1) % 2));
        end
      end else if (c == 5) begin
        chk("done_pulse", bus.done, 1);
        chk("done_busy", bus.busy, 1);
        chk("done_stall", bus.stall, 0);
        chk("done_wr_en", bus.wr_en, 0);
        chk("done_wr_addr", bus.wr_addr, 0);
        chk("done_wr_data", bus.wr_data, 0);
      end else begin
        chk("after_stall", bus.stall, 0);
        chk_idle("after");
      end
      if (c == flush_c) begin
        @(posedge clk); #1;
        bus.flush = 0; bus.start = 0;
        #3;
        chk("flush_stall", bus.stall, 0);
        chk_idle("flush");
        return;
      end
    end
    bus.start = 0;
  endtask

  initial begin
    bus.start = 0; bus.flush = 0; bus.a_mat = '0; bus.b_mat = '0; bus.dest_base = '0;
    #12;
    chk("rst_stall", bus.stall, 0);
    chk_idle("rst");
    rst_n = 1;
    run_op(32'h01000001, 32'h08070605, 3'd2, 0, 0);
    run_op(32'h10101010, 32'h10101010, 3'd0, 0, 0);
    run_op($urandom, $urandom, 3'd6, 0, 0);
    run_op($urandom, $urandom, 3'd1, 3, 0);
    run_op($urandom, $urandom, 3'd4, 0, 1);
    @(posedge clk); #1;
    bus.start = 1; bus.flush = 1;
    #3;
    chk("sf_stall", bus.stall, 0);
    @(posedge clk); #1;
    bus.start = 0; bus.flush = 0;
    #3;
    chk_idle("sf");
    @(posedge clk); #1;
    bus.start = 1; bus.a_mat = $urandom; bus.b_mat = $urandom; bus.dest_base = 3'd3;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      bus.start = 0;
    end
    #1;
    rst_n = 0;
    #1;
    chk("mid_rst_stall", bus.stall, 0);
    chk_idle("mid_rst");
    #3;
    rst_n = 1;
    run_op(32'h01000001, 32'h08070605, 3'd7, 0, 0);
    for (int n = 0; n < 20; n++)
      run_op($urandom, $urandom, 3'($urandom), 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
